// File: rtl/gray_counter_if.sv
// Counter control/status bundle: count enable, direction, optional load, outputs.
// Combinational wiring only; no latency of its own.
// No backpressure; the counter accepts a control value every cycle.
// Optional load signals exist only when GRAY_CNT_LOAD_EN is defined.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
`ifdef GRAY_CNT_LOAD_EN
  logic             ld;
  logic [WIDTH-1:0] ld_val;
`endif
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic             wrap;

  modport master (
    output en, up,
`ifdef GRAY_CNT_LOAD_EN
    output ld, ld_val,
`endif
    input  bin, gray, wrap
  );

  modport slave (
    input  en, up,
`ifdef GRAY_CNT_LOAD_EN
    input  ld, ld_val,
`endif
    output bin, gray, wrap
  );
endinterface

// File: rtl/gray_counter.sv
// Registered binary/Gray up-down counter with a one-cycle wrap pulse.
// Latency: controls sampled at edge N are visible on bin/gray/wrap after edge N.
// No backpressure; one step per cycle while en is high.
// Optional synchronous load is compiled in by defining GRAY_CNT_LOAD_EN.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  gray_counter_if.slave  bus
);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Next binary count: load beats counting, counting beats hold; gray derived from bin_d
  // so both registers update on the same edge and gray never lags bin.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
`ifdef GRAY_CNT_LOAD_EN
    if (bus.ld) begin
      bin_d  = bus.ld_val;
    end else
`endif
    if (bus.en) begin
      if (bus.up) begin
        bin_d  = bin_q + ONE;
        wrap_d = (bin_q == ALL_ONE);
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = (bin_q == '0);
      end
    end
    gray_d = bin_d ^ (bin_d >> 1);
  end

  // State registers; reset clears everything immediately without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.gray = gray_q;
  assign bus.wrap = wrap_q;
endmodule
